// File: rtl/tx_ctrl_pkg.sv
// Shared types and frame defaults for the Tx frame sequencer.
// Frame geometry defaults match the mapper include.
package tx_ctrl_pkg;

  localparam int FRAME_SYMB_DEF = 50;
  localparam int N_PREAM_DEF    = 2;
  localparam int SYM_W          = 6;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_DATA,
    RUN,
    STOPPING
  } tx_state_t;

  typedef struct packed {
    logic [2:0] M;
    logic [3:0] ss;
    logic [2:0] bw;
  } tx_cfg_t;

endpackage

// File: rtl/tx_frame_ctrl_if.sv
// Config write handshake between host and the frame sequencer.
// The host drives the fields and the strobe, and the sequencer returns ready.
interface tx_frame_ctrl_if;

  logic       cfg_valid;
  logic       cfg_ready;
  logic [2:0] cfg_M;
  logic [3:0] cfg_ss;
  logic [2:0] cfg_bw;

  modport master (
    output cfg_valid,
    output cfg_M,
    output cfg_ss,
    output cfg_bw,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_M,
    input  cfg_ss,
    input  cfg_bw,
    output cfg_ready
  );

endinterface

// File: rtl/tx_cfg_shadow.sv
// Shadow/active config pair with a single-entry pending handshake.
// Active only changes on the apply strobe.
module tx_cfg_shadow
  import tx_ctrl_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    wr_valid,
  input  tx_cfg_t wr_cfg,
  input  logic    apply,
  output logic    wr_ready,
  output tx_cfg_t active
);

  logic    pending;
  logic    wr_take;
  tx_cfg_t shadow;

  assign wr_take  = wr_valid && !pending;
  assign wr_ready = !pending;

  // A write landing with apply wins the pending bit; active takes the old shadow.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 1'b0;
      shadow  <= '0;
      active  <= '0;
    end else begin
      if (wr_take) begin
        shadow <= wr_cfg;
      end
      if (apply) begin
        active <= shadow;
      end
      if (wr_take) begin
        pending <= 1'b1;
      end else if (apply) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/tx_frame_ctrl.sv
// Frame sequencer for the Tx OFDM mapper: start/stop at frame granularity,
// per-symbol data/filler decision and frame-aligned config updates.
module tx_frame_ctrl
  import tx_ctrl_pkg::*;
#(
  parameter int FRAME_SYMB    = FRAME_SYMB_DEF,
  parameter int N_PREAM       = N_PREAM_DEF,
  parameter int DATA_PER_SYMB = 600,
  parameter int PREFILL       = 1200,
  parameter int LVL_W         = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  tx_frame_ctrl_if.slave      cfg,
  input  logic [LVL_W-1:0]    fifo_level,
  input  logic                map_oeop,
  output logic                enable,
  output logic                ready_frame,
  output logic                data_off,
  output logic [2:0]          index_M,
  output logic [3:0]          index_ss,
  output logic [2:0]          index_bw,
  output logic [SYM_W-1:0]    sym_idx,
  output logic                busy,
  output logic [15:0]         underflow_cnt
);

  tx_state_t        state_q;
  tx_state_t        state_d;
  logic             apply;
  logic             run;
  logic             sym_tick;
  logic             boundary;
  logic             pre_nx;
  logic             have_data;
  logic             prefilled;
  logic [SYM_W-1:0] sym_q;
  logic [SYM_W-1:0] sym_nx;
  logic             rf_q;
  logic             doff_q;
  logic [15:0]      uf_q;
  tx_cfg_t          wr_cfg;
  tx_cfg_t          act_cfg;

  assign wr_cfg = '{M: cfg.cfg_M, ss: cfg.cfg_ss, bw: cfg.cfg_bw};

  tx_cfg_shadow u_shadow (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (cfg.cfg_valid),
    .wr_cfg   (wr_cfg),
    .apply    (apply),
    .wr_ready (cfg.cfg_ready),
    .active   (act_cfg)
  );

  assign run       = (state_q == RUN) || (state_q == STOPPING);
  assign sym_tick  = run && map_oeop;
  assign boundary  = sym_tick && (sym_q == SYM_W'(FRAME_SYMB - 1));
  assign sym_nx    = boundary ? '0 : sym_q + 1'b1;
  assign pre_nx    = sym_nx < SYM_W'(N_PREAM);
  assign have_data = fifo_level >= LVL_W'(DATA_PER_SYMB);
  assign prefilled = fifo_level >= LVL_W'(PREFILL);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    apply   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          apply   = 1'b1;
          state_d = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (stop) begin
          state_d = IDLE;
        end else if (prefilled) begin
          state_d = RUN;
        end
      end
      RUN: begin
        apply = boundary;
        if (stop) begin
          state_d = STOPPING;
        end
      end
      STOPPING: begin
        apply = boundary;
        if (boundary) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Decision for the upcoming symbol is latched on its end-of-symbol pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      sym_q  <= '0;
      rf_q   <= 1'b0;
      doff_q <= 1'b0;
      uf_q   <= '0;
    end else if (!run || state_d == IDLE) begin
      sym_q  <= '0;
      rf_q   <= 1'b0;
      doff_q <= 1'b0;
    end else if (sym_tick) begin
      sym_q <= sym_nx;
      if (pre_nx) begin
        rf_q   <= 1'b0;
        doff_q <= 1'b0;
      end else if (have_data) begin
        rf_q   <= 1'b1;
        doff_q <= 1'b0;
      end else begin
        rf_q   <= 1'b0;
        doff_q <= 1'b1;
        if (uf_q != 16'hFFFF) begin
          uf_q <= uf_q + 16'd1;
        end
      end
    end
  end

  assign enable        = run;
  assign busy          = state_q != IDLE;
  assign sym_idx       = sym_q;
  assign ready_frame   = rf_q;
  assign data_off      = doff_q;
  assign underflow_cnt = uf_q;
  assign index_M       = act_cfg.M;
  assign index_ss      = act_cfg.ss;
  assign index_bw      = act_cfg.bw;

endmodule

// File: doc/tx_frame_ctrl.md
Name: tx_frame_ctrl

Overview:
Frame-level sequencer for the Tx OFDM mapper. It gates the mapper `enable` and holds per-frame configuration (modulation, spreading, bandwidth) in shadow and active registers. Config changes are applied only at frame boundaries. Per symbol, it decides from payload-FIFO fill level whether the mapper may request data (`ready_frame`) or must send a filler symbol (`data_off`). It also handles start/stop at frame granularity.

Parameters:
FRAME_SYMB, 50, symbols per frame, preambles included
N_PREAM, 2, preamble symbols at frame start
DATA_PER_SYMB, 600, payload words consumed by one data symbol
PREFILL, 1200, FIFO level required before first enable
LVL_W, 12, width of fifo_level

Ports:
clk  in  1  clock, symbol-rate domain of mapper
rst  in  1  reset; synchronous, active-high
start  in  1  pulse; begin transmission (honoured in IDLE only)
stop  in  1  pulse; end transmission at next frame boundary
cfg_valid  in  1  shadow config write strobe
cfg_ready  out  1  shadow register free to accept a write
cfg_M  in  3  modulation index
cfg_ss  in  4  spreading factor, 1..15
cfg_bw  in  3  bandwidth index
fifo_level  in  LVL_W  payload FIFO occupancy, words
map_oeop  in  1  mapper end-of-symbol pulse (1 clk)
enable  out  1  mapper enable
ready_frame  out  1  payload available for current symbol
data_off  out  1  force pilot/preamble map for current symbol
index_M  out  3  active modulation to mapper
index_ss  out  4  active spreading factor
index_bw  out  3  active bandwidth index
sym_idx  out  6  symbol index within frame, 0..FRAME_SYMB-1
busy  out  1  state != IDLE
underflow_cnt  out  16  filler symbols inserted, saturating

Behaviour:
- Reset: state=IDLE. All outputs 0 except `cfg_ready`=1. Shadow registers, active registers and `stop_pending` are cleared. Mid-operation reset aborts immediately; `enable` drops on the next edge.
- Shadow config:
  - `cfg_valid & cfg_ready` captures `cfg_*` and sets `pending`.
  - `cfg_ready = ~pending`.
  - `cfg_valid` while `pending` is ignored.
- FSM states: IDLE, WAIT_DATA, RUN, STOPPING.
  - IDLE: `enable`=0. On `start` (and `stop`=0): copy shadow to active, clear `pending`, go to WAIT_DATA. `start & stop` in the same cycle: stay in IDLE.
  - WAIT_DATA: `enable`=0. When `fifo_level >= PREFILL`: go to RUN, `enable`=1 next cycle, `sym_idx`=0. `stop` here: return to IDLE.
  - RUN: `enable`=1. On each `map_oeop`, `sym_idx` increments and wraps FRAME_SYMB-1 -> 0.
    - Frame boundary = `map_oeop` with `sym_idx == FRAME_SYMB-1`.
    - At the boundary, if `pending`: shadow -> active, `pending` clears, `cfg_ready` rises next cycle.
    - A `cfg_valid` write in the boundary cycle is not applied until the following boundary.
    - `stop` in RUN sets `stop_pending` and moves to STOPPING.
  - STOPPING: behaves as RUN. At the frame boundary: go to IDLE, `enable`=0 next cycle, `sym_idx`=0. A repeated `stop` has no effect. `start` is ignored in all non-IDLE states.
- Per-symbol decision:
  - Registered on `map_oeop` for the upcoming symbol (`sym_idx` next value `n`).
  - Held constant for the whole symbol.
  - If `n < N_PREAM`: `ready_frame`=0, `data_off`=0.
  - Else if `fifo_level >= DATA_PER_SYMB`: `ready_frame`=1, `data_off`=0.
  - Otherwise: `ready_frame`=0, `data_off`=1, `underflow_cnt` += 1, saturating at 0xFFFF.
  - First symbol after entering RUN is `sym_idx` 0 (preamble), so `ready_frame`=0 and `data_off`=0.
- Decisions take effect one clk after `map_oeop`, i.e. inside the CP gap, before the mapper's next active region.
- `index_*` outputs come from the active registers. They are stable for a whole frame and retained in IDLE.

Decomposition:
- Package `tx_ctrl_pkg`:
  - state enum `tx_state_t` (IDLE, WAIT_DATA, RUN, STOPPING)
  - struct `tx_cfg_t` {M[2:0], ss[3:0], bw[2:0]}
  - FRAME_SYMB and N_PREAM defaults, shared with the mapper include.
- Sub-module `tx_cfg_shadow`: shadow/active register pair with the `pending`/`cfg_ready` handshake and the apply strobe. The FSM and symbol logic stay in the top module.

Test Plan:
- Write cfg M=6, ss=2, bw=1; `start`; `fifo_level`=1200 -> `enable` rises 1 clk after WAIT_DATA sees the level; `index_M`=6; `sym_idx` 0,1 give `ready_frame`=0; `sym_idx`=2 gives `ready_frame`=1.
- In RUN with `fifo_level` held at 599 at `sym_idx`=10's `map_oeop` -> `data_off`=1 for that symbol, `underflow_cnt`=1; restore to 600 -> next symbol `ready_frame`=1, `data_off`=0.
- Write cfg M=4 at `sym_idx`=20 -> `cfg_ready`=0, `index_M` stays 6 until the boundary `map_oeop` (`sym_idx`=49), then 4; `cfg_ready`=1 next cycle; second write during pending is ignored.
- `stop` at `sym_idx`=5 -> `enable` stays 1 through `sym_idx`=49, drops 1 clk after the boundary `map_oeop`; `busy`=0; later `start` resumes with the retained config.
- Assert `rst` mid-frame (`sym_idx`=30) -> next edge: `enable`=0, `sym_idx`=0, `cfg_ready`=1, `underflow_cnt`=0, state IDLE; `start` in the same cycle as `stop` in IDLE -> remains IDLE.
